// File: rtl/gng_sched_pkg.sv
// Shared types and sizing helpers for the Gaussian noise sample scheduler.
package gng_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Generator sample width, s<16,11> carried in a 32-bit word.
  localparam int SAMPLE_W = 32;

  // Width of a counter that must be able to hold the value 'depth'.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/gng_sched_fifo.sv
// Sample buffer between the noise generator and the granted requester.
// The caller guarantees push only when not full and pop only when not empty.
module gng_sched_fifo
  import gng_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = SAMPLE_W,
  localparam int CNT_W = cnt_width(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/gng_noise_sched.sv
// Shares one Gaussian noise generator between NUM_REQ requesters.
// The generator is prefetched with credits so the FIFO fills even while idle;
// requesters are granted round-robin and receive bursts of req_len samples.
//
// Handshakes: a sample transfers on a clock edge where out_valid and out_ready
// are both high. out_valid never depends on out_ready, and once out_valid is
// high out_data/out_id/out_last hold until that transfer happens. req_ready is
// a one-cycle pulse that accepts the request regardless of later req_valid.
module gng_noise_sched
  import gng_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 12,
  localparam int ID_W  = $clog2(NUM_REQ),
  localparam int CNT_W = cnt_width(FIFO_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     gng_ce,
  input  logic                     gng_valid,
  input  logic [SAMPLE_W-1:0]      gng_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SAMPLE_W-1:0]      out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_last,
  output logic                     busy,
  output logic                     ovf
);

  state_t             state_q;
  logic [ID_W-1:0]    grant_id_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    out_id_q;
  logic [LEN_W-1:0]   rem_q;
  logic [CNT_W-1:0]   inflight_q;
  logic [CNT_W-1:0]   fifo_count;
  logic [SAMPLE_W-1:0] fifo_head;
  logic               run_q;
  logic               ovf_q;

  logic               fifo_full;
  logic               fifo_push;
  logic               hs;
  logic               pick_found;
  logic [ID_W-1:0]    pick_id;
  logic [LEN_W-1:0]   pick_len;

  assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_push = gng_valid & ~fifo_full;
  assign hs        = out_valid & out_ready;

  // Credit check: never ask for more samples than the FIFO can hold.
  // run_q keeps the enable low while reset is asserted.
  assign gng_ce = run_q &
                  (({1'b0, fifo_count} + {1'b0, inflight_q}) < (CNT_W + 1)'(FIFO_DEPTH));

  gng_sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .pop   (hs),
    .din   (gng_data),
    .head  (fifo_head),
    .count (fifo_count)
  );

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    logic [ID_W-1:0] idx;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx;
      end
    end
  end

  assign pick_len = req_len[int'(pick_id)*LEN_W +: LEN_W];

  // Outstanding generator requests; the generator answers each ce exactly once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight_q <= '0;
      run_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case ({gng_ce, gng_valid})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
      if (gng_valid && fifo_full) ovf_q <= 1'b1;
    end
  end

  // Arbitration and burst FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= ID_W'(NUM_REQ - 1);
      out_id_q   <= '0;
      rem_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_id_q <= pick_id;
            rem_q      <= pick_len;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          rr_ptr_q <= grant_id_q;
          if (rem_q == '0) begin
            state_q <= IDLE;
          end else begin
            out_id_q <= grant_id_q;
            state_q  <= STREAM;
          end
        end
        STREAM: begin
          if (hs) begin
            rem_q <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == GRANT) ? (NUM_REQ'(1) << grant_id_q) : '0;
  assign out_valid = (state_q == STREAM) && (fifo_count != '0);
  assign out_last  = (state_q == STREAM) && (rem_q == LEN_W'(1));
  assign out_data  = out_valid ? fifo_head : '0;
  assign out_id    = out_id_q;
  assign busy      = (state_q != IDLE);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_gng_noise_sched.sv
// Bench for gng_noise_sched with a latency-5 generator model.
module tb_gng_noise_sched;

  localparam int NUM_REQ    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int LEN_W      = 12;
  localparam int ID_W       = 2;
  localparam int LAT        = 5;

  // ---------------- clock / reset / signals ----------------
  logic                     clk = 1'b0;
  logic                     rstn;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     gng_ce;
  logic                     gng_valid;
  logic [31:0]              gng_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_data;
  logic [ID_W-1:0]          out_id;
  logic                     out_last;
  logic                     busy;
  logic                     ovf;

  always #5 clk = ~clk;

  gng_noise_sched #(
    .NUM_REQ    (NUM_REQ),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LEN_W      (LEN_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_len   (req_len),
    .req_ready (req_ready),
    .gng_ce    (gng_ce),
    .gng_valid (gng_valid),
    .gng_data  (gng_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last),
    .busy      (busy),
    .ovf       (ovf)
  );

  // ---------------- generator model + scoreboard ----------------
  logic [31:0]    exp_q[$];
  logic [LAT-1:0] vpipe;
  logic [31:0]    dpipe [LAT];
  logic [31:0]    seq;
  logic [7:0]     epoch;

  // One sample per ce, LAT cycles later; samples tagged with the reset epoch.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vpipe <= '0;
      seq   <= '0;
      for (int i = 0; i < LAT; i++) dpipe[i] <= '0;
      exp_q.delete();
    end else begin
      if (gng_valid) exp_q.push_back(gng_data);
      vpipe    <= {vpipe[LAT-2:0], gng_ce};
      dpipe[0] <= gng_ce ? {epoch, 8'hA5, seq[15:0]} : 32'h0;
      for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
      if (gng_ce) seq <= seq + 32'd1;
    end
  end

  assign gng_valid = vpipe[LAT-1];
  assign gng_data  = dpipe[LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_grant(output int cyc, output logic [NUM_REQ-1:0] rdy);
    cyc = 0;
    rdy = '0;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (req_ready != '0) begin
        rdy = req_ready;
        return;
      end
    end
  endtask

  // Consume 'stop' samples of a burst of 'len'; toggle stalls every other cycle.
  task automatic collect(input int len, input int id, input bit toggle, input int stop);
    int          n = 0;
    int          guard = 0;
    bit          stalled = 0;
    logic [31:0] sd;
    logic        sl;
    logic [31:0] e;
    while (n < stop) begin
      @(negedge clk);
      guard++;
      if (guard > 400) begin
        checks++;
        errors++;
        $display("FAIL collect_timeout: got %0d samples expected %0d", n, stop);
        return;
      end
      if (guard == 1) check("req_ready_pulse", 32'(req_ready), 32'h0);
      if (stalled) begin
        check("stall_valid", 32'(out_valid), 32'h1);
        check("stall_data", out_data, sd);
        check("stall_last", 32'(out_last), 32'(sl));
        check("stall_id", 32'(out_id), 32'(id));
        stalled = 0;
      end
      out_ready = toggle ? ~out_ready : 1'b1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL data_underflow: got %0h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("data", out_data, e);
        end
        check("id", 32'(out_id), 32'(id));
        check("last", 32'(out_last), 32'(n == len - 1));
        n++;
      end else if (out_valid) begin
        stalled = 1;
        sd      = out_data;
        sl      = out_last;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    check({tag, "_gng_ce"},    32'(gng_ce),    32'h0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_out_data"},  out_data,       32'h0);
    check({tag, "_out_id"},    32'(out_id),    32'h0);
    check({tag, "_out_last"},  32'(out_last),  32'h0);
    check({tag, "_busy"},      32'(busy),      32'h0);
    check({tag, "_ovf"},       32'(ovf),       32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [ID_W-1:0]    id;
    logic [LEN_W-1:0]   len;
    bit                 toggle;
    logic [NUM_REQ-1:0] exp_ready;
  } row_t;

  row_t rows[5];

  task automatic run_row(input row_t r);
    int                 cyc;
    logic [NUM_REQ-1:0] rdy;
    req_len = '0;
    req_len[int'(r.id)*LEN_W +: LEN_W] = r.len;
    req_valid = NUM_REQ'(1) << r.id;
    wait_grant(cyc, rdy);
    check("grant_latency", 32'(cyc), 32'd1);
    check("req_ready", 32'(rdy), 32'(r.exp_ready));
    check("busy_in_grant", 32'(busy), 32'h1);
    check("valid_in_grant", 32'(out_valid), 32'h0);
    req_valid = '0;
    if (r.len != '0) collect(int'(r.len), int'(r.id), r.toggle, int'(r.len));
    @(negedge clk);
    check("busy_after", 32'(busy), 32'h0);
    check("valid_after", 32'(out_valid), 32'h0);
    check("ovf_after", 32'(ovf), 32'h0);
    check("rr_ptr", 32'(dut.rr_ptr_q), 32'(r.id));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int                 ce_n;
    int                 cyc;
    logic [NUM_REQ-1:0] rdy;
    int                 order[4];
    row_t               mid;

    rows[0] = '{id: 2'd2, len: 12'd3,  toggle: 1'b0, exp_ready: 4'b0100};
    rows[1] = '{id: 2'd1, len: 12'd0,  toggle: 1'b0, exp_ready: 4'b0010};
    rows[2] = '{id: 2'd2, len: 12'd20, toggle: 1'b1, exp_ready: 4'b0100};
    rows[3] = '{id: 2'd3, len: 12'd1,  toggle: 1'b0, exp_ready: 4'b1000};
    rows[4] = '{id: 2'd0, len: 12'd5,  toggle: 1'b1, exp_ready: 4'b0001};
    order   = '{0, 1, 3, 0};

    epoch     = 8'd1;
    rstn      = 1'b0;
    req_valid = '0;
    req_len   = '0;
    out_ready = 1'b0;

    // Reset values, then idle prefetch fills the FIFO with exactly 8 credits.
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    ce_n = 0;
    repeat (20) begin
      @(negedge clk);
      if (gng_ce) ce_n++;
    end
    check("idle_ce_cycles", 32'(ce_n), 32'd8);
    check("idle_count", 32'(dut.fifo_count), 32'd8);
    check("idle_inflight", 32'(dut.inflight_q), 32'd0);
    check("idle_ovf", 32'(ovf), 32'h0);
    check("idle_out_valid", 32'(out_valid), 32'h0);

    // Three simultaneous requesters from reset: order 0,1,3 then 0 again.
    req_valid = 4'b1011;
    req_len   = {4{12'd2}};
    for (int g = 0; g < 4; g++) begin
      wait_grant(cyc, rdy);
      check("rr_latency", 32'(cyc), (g == 0) ? 32'd1 : 32'd2);
      check("rr_grant", 32'(rdy), 32'(NUM_REQ'(1) << order[g]));
      if (g == 3) req_valid = '0;
      collect(2, order[g], 1'b0, 2);
    end
    @(negedge clk);
    check("rr_busy_end", 32'(busy), 32'h0);

    // Table of single-requester bursts.
    for (int r = 0; r < 5; r++) run_row(rows[r]);

    // Reset in the middle of a burst with 7 samples remaining.
    req_len   = '0;
    req_len[1*LEN_W +: LEN_W] = 12'd20;
    req_valid = 4'b0010;
    wait_grant(cyc, rdy);
    check("mid_grant", 32'(rdy), 32'h2);
    req_valid = '0;
    collect(20, 1, 1'b0, 13);
    @(negedge clk);
    out_ready = 1'b0;
    check("mid_rem", 32'(dut.rem_q), 32'd7);
    check("mid_out_id_before", 32'(out_id), 32'd1);
    epoch = 8'd2;
    rstn  = 1'b0;
    #1;
    check_reset_outputs("midreset");
    check("midreset_count", 32'(dut.fifo_count), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    check("release_count", 32'(dut.fifo_count), 32'd0);
    repeat (20) @(negedge clk);
    check("refill_count", 32'(dut.fifo_count), 32'd8);
    check("refill_inflight", 32'(dut.inflight_q), 32'd0);
    mid = '{id: 2'd3, len: 12'd4, toggle: 1'b0, exp_ready: 4'b1000};
    run_row(mid);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the sequence ever wedges.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
